// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, constants and types for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    // Instruction value shown to decode whenever nothing valid is presented.
    localparam logic [INSTR_W-1:0] c_nop_instr = 16'h0000;

    // Default word address loaded into the PC on reset.
    localparam logic [ADDR_W-1:0] c_reset_pc = 16'h0000;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    // One prefetch slot: the address is filled at request time, the word
    // when the matching response returns.
    typedef struct packed {
        addr_t  addr;
        instr_t data;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH x {addr,data} prefetch FIFO. The address half is written
//               when a request is issued, the data half when its response
//               returns, through independent write pointers. count and head
//               reflect entries whose data has arrived.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   addr_push,
    input  logic [ADDR_W-1:0]      addr_in,
    input  logic                   data_push,
    input  logic [INSTR_W-1:0]     data_in,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output logic [ADDR_W-1:0]      head_addr,
    output logic [INSTR_W-1:0]     head_data
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] c_ptr_one = (PW+1)'(1);
    localparam logic [PW:0] c_full    = (PW+1)'(DEPTH);

    fetch_entry_t r_mem [DEPTH];

    // Pointers carry one extra wrap bit so that full and empty differ.
    logic [PW:0] r_awptr;
    logic [PW:0] r_dwptr;
    logic [PW:0] r_rptr;
    logic [PW:0] w_addr_used;

    assign count       = r_dwptr - r_rptr;
    assign w_addr_used = r_awptr - r_rptr;
    assign head_addr   = r_mem[r_rptr[PW-1:0]].addr;
    assign head_data   = r_mem[r_rptr[PW-1:0]].data;

    // Pointer update; flush drops every slot, both halves.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_awptr <= '0;
            r_dwptr <= '0;
            r_rptr  <= '0;
        end else begin
            if (addr_push) r_awptr <= r_awptr + c_ptr_one;
            if (data_push) r_dwptr <= r_dwptr + c_ptr_one;
            if (pop)       r_rptr  <= r_rptr + c_ptr_one;
        end
    end

    // Storage write: address and data halves land in different slots.
    always_ff @(posedge clk) begin
        if (addr_push) r_mem[r_awptr[PW-1:0]].addr <= addr_in;
        if (data_push) r_mem[r_dwptr[PW-1:0]].data <= data_in;
    end

    // Overflow guard: the upstream credit scheme must never overfill a half.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(data_push && !pop && (count == c_full)));
            assert (!(addr_push && !pop && (w_addr_used == c_full)));
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch. Owns the PC, issues word requests under a
//               DEPTH credit limit, buffers in-order responses and presents
//               them to decode. A branch redirect flushes the buffer and
//               drops the responses still in flight (drain via r_discard).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = c_reset_pc,
    parameter int                DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    output logic [ADDR_W-1:0]   imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic                stall,
    output logic [INSTR_W-1:0]  instruction,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [ADDR_W-1:0]   pc_plus1,
    output logic                instr_valid
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     c_one     = CW'(1);
    localparam logic [CW:0]       c_depth   = (CW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    logic [ADDR_W-1:0]  r_pc;
    logic [CW-1:0]      r_outstanding;
    logic [CW-1:0]      r_discard;

    logic [CW-1:0]      w_count;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [INSTR_W-1:0] w_head_data;
    logic [CW:0]        w_inflight;
    logic               w_fire;
    logic               w_keep;
    logic               w_pop;
    logic               w_valid;
    logic [CW-1:0]      w_out_next;

    // Credits cover both words in flight and words already buffered.
    assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_count};
    assign imem_req_valid = !rst && !branch_taken && (w_inflight < c_depth);
    assign imem_req_addr  = r_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;

    // A response is kept only outside a drain and outside a redirect cycle.
    assign w_keep  = imem_rsp_valid && !branch_taken && (r_discard == '0);
    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid && !stall && !branch_taken;

    assign instr_valid = w_valid;
    assign instruction = w_valid ? w_head_data : c_nop_instr;
    assign pc_out      = w_valid ? w_head_addr : '0;
    assign pc_plus1    = pc_out + c_addr_one;

    // Next outstanding count: a fire and a response in one cycle cancel.
    always_comb begin
        w_out_next = r_outstanding;
        if (w_fire && !imem_rsp_valid) begin
            w_out_next = r_outstanding + c_one;
        end else if (!w_fire && imem_rsp_valid) begin
            w_out_next = r_outstanding - c_one;
        end
    end

    // PC, in-flight and drain counters; a redirect reloads the drain count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (branch_taken) begin
                r_pc      <= branch_target;
                r_discard <= w_out_next;
            end else begin
                if (w_fire) begin
                    r_pc <= r_pc + c_addr_one;
                end
                if (imem_rsp_valid && (r_discard != '0)) begin
                    r_discard <= r_discard - c_one;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (branch_taken),
        .addr_push (w_fire),
        .addr_in   (r_pc),
        .data_push (w_keep),
        .data_in   (imem_rsp_data),
        .pop       (w_pop),
        .count     (w_count),
        .head_addr (w_head_addr),
        .head_data (w_head_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed vector bench for fetch_stage with an in-order,
//               variable-latency instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready = 1'b1;
    logic        rsp_valid = 1'b0;
    logic [15:0] rsp_data  = 16'h0000;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        stall = 1'b0;
    logic [15:0] instruction;
    logic [15:0] pc_out;
    logic [15:0] pc_plus1;
    logic        instr_valid;

    int n_vec = 0;
    int n_err = 0;
    int mem_lat = 1;
    int cyc = 0;

    fetch_stage #(
        .RESET_PC (16'h0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (req_valid),
        .imem_req_addr  (req_addr),
        .imem_req_ready (req_ready),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .stall          (stall),
        .instruction    (instruction),
        .pc_out         (pc_out),
        .pc_plus1       (pc_plus1),
        .instr_valid    (instr_valid)
    );

    always #5 clk = ~clk;

    // Memory contents: every word is distinguishable from its address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    // In-order memory: an accepted request answers mem_lat cycles later,
    // at most one response per cycle.
    typedef struct {
        logic [15:0] addr;
        int          due;
    } req_t;
    req_t mq[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            mq.delete();
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0000;
        end else begin
            if (req_valid && req_ready) begin
                mq.push_back('{req_addr, cyc + mem_lat});
            end
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                rsp_valid <= 1'b1;
                rsp_data  <= mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                rsp_valid <= 1'b0;
                rsp_data  <= 16'hDEAD;
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        rdy;
        int          lat;
        logic        chk;
        logic        rv;
        logic [15:0] ra;
        logic        iv;
        logic [15:0] pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [15:0] t,
                                input logic rd, input int l, input logic c, input logic rv,
                                input logic [15:0] ra, input logic iv, input logic [15:0] pc);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.rdy = rd; v.lat = l;
        v.chk = c; v.rv = rv; v.ra = ra; v.iv = iv; v.pc = pc;
        return v;
    endfunction

    // Drive one cycle's inputs mid-cycle, then compare the outputs.
    task automatic apply(input vec_t v, input string tag);
        logic [15:0] exp_p1;
        @(negedge clk);
        rst           = v.rst;
        stall         = v.stall;
        branch_taken  = v.br;
        branch_target = v.tgt;
        req_ready     = v.rdy;
        mem_lat       = v.lat;
        #1;
        if (v.chk) begin
            n_vec++;
            if (req_valid !== v.rv) begin
                n_err++;
                $display("FAIL %s req_valid got %b want %b", tag, req_valid, v.rv);
            end
            if (req_addr !== v.ra) begin
                n_err++;
                $display("FAIL %s req_addr got %h want %h", tag, req_addr, v.ra);
            end
            if (instr_valid !== v.iv) begin
                n_err++;
                $display("FAIL %s instr_valid got %b want %b", tag, instr_valid, v.iv);
            end
            if (v.iv) begin
                exp_p1 = v.pc + 16'h0001;
                if (pc_out !== v.pc) begin
                    n_err++;
                    $display("FAIL %s pc_out got %h want %h", tag, pc_out, v.pc);
                end
                if (pc_plus1 !== exp_p1) begin
                    n_err++;
                    $display("FAIL %s pc_plus1 got %h want %h", tag, pc_plus1, exp_p1);
                end
                if (instruction !== mem_word(v.pc)) begin
                    n_err++;
                    $display("FAIL %s instruction got %h want %h", tag, instruction, mem_word(v.pc));
                end
            end else if (instruction !== 16'h0000) begin
                n_err++;
                $display("FAIL %s instruction got %h want 0000", tag, instruction);
            end
        end
    endtask

    initial begin
        // ---- streaming, zero-wait memory, then a 5-cycle stall ----
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h0000, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h0001, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h0002, 1,16'h0000));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h0003, 1,16'h0001));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h0004, 1,16'h0002));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h0005, 1,16'h0003));
        vecs.push_back(mk(0,1,0,16'h0,1,1, 1, 1,16'h0006, 1,16'h0004));
        vecs.push_back(mk(0,1,0,16'h0,1,1, 1, 1,16'h0007, 1,16'h0004));
        vecs.push_back(mk(0,1,0,16'h0,1,1, 1, 0,16'h0008, 1,16'h0004));
        vecs.push_back(mk(0,1,0,16'h0,1,1, 1, 0,16'h0008, 1,16'h0004));
        vecs.push_back(mk(0,1,0,16'h0,1,1, 1, 0,16'h0008, 1,16'h0004));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 0,16'h0008, 1,16'h0004));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h0008, 1,16'h0005));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h0009, 1,16'h0006));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h000A, 1,16'h0007));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h000B, 1,16'h0008));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h000C, 1,16'h0009));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h000D, 1,16'h000A));
        // ---- latency 3: redirect on a response cycle, then redirect in drain ----
        vecs.push_back(mk(1,0,0,16'h0,1,3, 0, 0,16'h0000, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 1,16'h0000, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 1,16'h0001, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 1,16'h0002, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 1,16'h0003, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 0,16'h0004, 1,16'h0000));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 1,16'h0004, 1,16'h0001));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 1,16'h0005, 1,16'h0002));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 1,16'h0006, 1,16'h0003));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 1,16'h0007, 0,16'h0));
        vecs.push_back(mk(0,0,1,16'h0040,1,3, 1, 0,16'h0008, 1,16'h0004));
        vecs.push_back(mk(0,0,1,16'h0080,1,3, 1, 0,16'h0040, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 1,16'h0080, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 1,16'h0081, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 1,16'h0082, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 1,16'h0083, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 0,16'h0084, 1,16'h0080));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 1,16'h0084, 1,16'h0081));
        vecs.push_back(mk(0,0,0,16'h0,1,3, 1, 1,16'h0085, 1,16'h0082));
        // ---- ready low 3 cycles, then latency 4: credit limit of DEPTH ----
        vecs.push_back(mk(1,0,0,16'h0,1,4, 0, 0,16'h0000, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,0,4, 1, 1,16'h0000, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,0,4, 1, 1,16'h0000, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,0,4, 1, 1,16'h0000, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,4, 1, 1,16'h0000, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,4, 1, 1,16'h0001, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,4, 1, 1,16'h0002, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,4, 1, 1,16'h0003, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,4, 1, 0,16'h0004, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,4, 1, 0,16'h0004, 1,16'h0000));
        vecs.push_back(mk(0,0,0,16'h0,1,4, 1, 1,16'h0004, 1,16'h0001));
        vecs.push_back(mk(0,0,0,16'h0,1,4, 1, 1,16'h0005, 1,16'h0002));
        vecs.push_back(mk(0,0,0,16'h0,1,4, 1, 1,16'h0006, 1,16'h0003));
        vecs.push_back(mk(0,0,0,16'h0,1,4, 1, 1,16'h0007, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,4, 1, 0,16'h0008, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,4, 1, 0,16'h0008, 1,16'h0004));
        // ---- redirect to 16'hFFFF: PC wrap and pc_plus1 wrap ----
        vecs.push_back(mk(1,0,0,16'h0,1,1, 0, 0,16'h0000, 0,16'h0));
        vecs.push_back(mk(0,0,1,16'hFFFF,1,1, 1, 0,16'h0000, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'hFFFF, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h0000, 0,16'h0));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h0001, 1,16'hFFFF));
        vecs.push_back(mk(0,0,0,16'h0,1,1, 1, 1,16'h0002, 1,16'h0000));

        // Initial reset: two reset edges, then the reset state itself.
        apply(mk(1,0,0,16'h0,1,1, 0, 0,16'h0000, 0,16'h0), "rst_a");
        apply(mk(1,0,0,16'h0,1,1, 1, 0,16'h0000, 0,16'h0), "rst_state");
        n_vec++;
        if (pc_out !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_pc_out got %h want 0000", pc_out);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-stream: pre-reset state is visible, then a clean restart.
        apply(mk(1,0,0,16'h0,1,1, 1, 0,16'h0003, 1,16'h0001), "mrst_hold");
        apply(mk(0,0,0,16'h0,1,1, 1, 1,16'h0000, 0,16'h0),    "mrst_after");
        apply(mk(0,0,0,16'h0,1,1, 1, 1,16'h0001, 0,16'h0),    "mrst_1");
        apply(mk(0,0,0,16'h0,1,1, 1, 1,16'h0002, 1,16'h0000), "mrst_2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
